// File: rtl/mips_datapath_memory_arbiter_pkg.sv
// mips_datapath_memory_arbiter_pkg: shared encodings and sizing for the data-RAM arbiter
package mips_datapath_memory_arbiter_pkg;
   typedef enum logic {IDLE, LOCKED} state_t;
   typedef enum logic {CORE, LOADER} owner_t;
   localparam int DEF_MAX_WAIT = 8;
   function automatic int wait_w(input int max_wait);
      return $clog2(max_wait + 1);
   endfunction
endpackage

// File: rtl/mips_datapath_memory_arbiter_if.sv
// mips_datapath_memory_arbiter_if: core, loader and RAM buses of the data-RAM arbiter
interface mips_datapath_memory_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              core_req, core_we, core_gnt, core_stall, core_rvalid;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata, core_rdata;
   logic              loader_req, loader_we, loader_lock, loader_gnt, loader_rvalid;
   logic [ADDR_W-1:0] loader_addr;
   logic [DATA_W-1:0] loader_wdata, loader_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  loader_req, loader_we, loader_lock, loader_addr, loader_wdata, ram_rdata,
      output core_gnt, core_stall, core_rvalid, core_rdata,
      output loader_gnt, loader_rvalid, loader_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata
   );
   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output loader_req, loader_we, loader_lock, loader_addr, loader_wdata, ram_rdata,
      input  core_gnt, core_stall, core_rvalid, core_rdata,
      input  loader_gnt, loader_rvalid, loader_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mips_datapath_memory_arbiter_age.sv
// mips_datapath_memory_arbiter_age: saturating count of consecutive denied loader cycles
module mips_datapath_memory_arbiter_age
   import mips_datapath_memory_arbiter_pkg::*;
#(
   parameter  int MAX_WAIT = DEF_MAX_WAIT,
   localparam int W        = wait_w(MAX_WAIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_sat
);
   logic [W-1:0] r_cnt;
   assign o_sat = r_cnt == W'(MAX_WAIT);
   // count up while the loader is refused, hold at the threshold, clear on grant or idle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_inc && !o_sat) r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/mips_datapath_memory_arbiter.sv
// mips_datapath_memory_arbiter: core/loader arbiter for the shared data RAM
// Optional loader burst lock: MIPS_DATAPATH_MEMORY_ARBITER_LOCK_EN
module mips_datapath_memory_arbiter
   import mips_datapath_memory_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input logic clk,
   input logic rst_n,
   mips_datapath_memory_arbiter_if.slave bus
);
   logic              w_force, w_lock_act, w_core_gnt, w_loader_gnt, w_sat;
   logic              w_inc, w_clr, w_en, w_we, r_rvalid;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   owner_t            r_owner;
   assign w_inc = bus.loader_req & ~w_loader_gnt;
   assign w_clr = w_loader_gnt | ~bus.loader_req;
   mips_datapath_memory_arbiter_age #(.MAX_WAIT(MAX_WAIT)) u_age (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_inc),
      .i_clr (w_clr),
      .o_sat (w_sat)
   );
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_LOCK_EN
   state_t r_state;
   // a held lock keeps the RAM for the loader; dropping it restores IDLE rules in the same cycle
   assign w_lock_act = (r_state == LOCKED) & bus.loader_lock;
   // enter LOCKED on a locked loader grant, stay while the lock is held
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= (bus.loader_lock & (w_loader_gnt | w_lock_act)) ? LOCKED : IDLE;
`else
   assign w_lock_act = 1'b0;
`endif
   assign w_force      = w_sat & bus.loader_req;
   assign w_loader_gnt = rst_n & bus.loader_req & (w_lock_act | w_force | ~bus.core_req);
   assign w_core_gnt   = rst_n & bus.core_req & ~w_lock_act & ~w_force;
   assign w_en         = w_core_gnt | w_loader_gnt;
   assign w_we         = w_core_gnt ? bus.core_we : w_loader_gnt & bus.loader_we;
   assign w_addr       = w_core_gnt ? bus.core_addr : w_loader_gnt ? bus.loader_addr : '0;
   assign w_wdata      = w_core_gnt ? bus.core_wdata : w_loader_gnt ? bus.loader_wdata : '0;
   assign bus.core_gnt   = w_core_gnt;
   assign bus.loader_gnt = w_loader_gnt;
   assign bus.core_stall = rst_n & bus.core_req & ~w_core_gnt;
   assign bus.ram_en     = w_en;
   assign bus.ram_we     = w_we;
   assign bus.ram_addr   = w_addr;
   assign bus.ram_wdata  = w_wdata;
   // remember who issued this cycle's read so next cycle's RAM data reaches its owner
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_owner  <= CORE;
      end else begin
         r_rvalid <= w_en & ~w_we;
         r_owner  <= w_loader_gnt ? LOADER : CORE;
      end
   assign bus.core_rvalid   = r_rvalid & (r_owner == CORE);
   assign bus.loader_rvalid = r_rvalid & (r_owner == LOADER);
   assign bus.core_rdata    = bus.core_rvalid ? bus.ram_rdata : '0;
   assign bus.loader_rdata  = bus.loader_rvalid ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_mips_datapath_memory_arbiter.sv
// tb_mips_datapath_memory_arbiter: vector table, corner sequences and randomized model check
`timescale 1ns/1ps
module tb_mips_datapath_memory_arbiter;
   localparam int AW = 9, DW = 32, MW = 8;
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif
   typedef struct {
      logic cr, cw, lr, lw;
      logic [AW-1:0] ca, la;
      logic [DW-1:0] cd, ld;
      logic cg, lg, st, we;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic crv, lrv;
      logic [DW-1:0] erd;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int total = 0, bad = 0;
   logic [DW-1:0] mem [512];
   logic [DW-1:0] ref_mem [512];
   vec_t tv [9];
   mips_datapath_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mips_datapath_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // synchronous single-port RAM
   always @(posedge clk)
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         else bus.ram_rdata <= mem[bus.ram_addr];
      end
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask
   task automatic idle();
      bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
      bus.loader_req = 0; bus.loader_we = 0; bus.loader_lock = 0;
      bus.loader_addr = '0; bus.loader_wdata = '0;
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic age_run(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_lgnt"}, bus.loader_gnt, (i % 9) == 8);
         chk({tag, "_cgnt"}, bus.core_gnt, (i % 9) != 8);
         chk({tag, "_stall"}, bus.core_stall, (i % 9) == 8);
         nxt();
      end
   endtask
   // reference model state
   int m_wait;
   bit m_locked, p_v, p_ld, c_pend, l_pend;
   logic [DW-1:0] p_d;
   initial begin
      int we_cnt;
      bit lock_act, force_l, ecg, elg;
      logic [AW-1:0] ga;
      for (int i = 0; i < 512; i++) mem[i] = '0;
      mem[16] = 32'hDEADBEEF; mem[17] = 32'h11111111; mem[18] = 32'h22222222;
      tv[0] = '{0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0};
      tv[1] = '{1,0,0,0, 9'h010,0, 0,0, 1,0,0,0, 9'h010,0, 1,0, 32'hDEADBEEF};
      tv[2] = '{1,1,0,0, 9'h050,0, 32'hA5A5A5A5,0, 1,0,0,1, 9'h050,32'hA5A5A5A5, 0,0, 0};
      tv[3] = '{0,0,1,0, 0,9'h011, 0,0, 0,1,0,0, 9'h011,0, 0,1, 32'h11111111};
      tv[4] = '{0,0,1,1, 0,9'h060, 0,32'h5A5A5A5A, 0,1,0,1, 9'h060,32'h5A5A5A5A, 0,0, 0};
      tv[5] = '{1,0,1,0, 9'h012,9'h011, 0,0, 1,0,0,0, 9'h012,0, 1,0, 32'h22222222};
      tv[6] = '{1,1,1,1, 9'h070,9'h071, 32'h77,32'h88, 1,0,0,1, 9'h070,32'h77, 0,0, 0};
      tv[7] = '{1,0,0,0, 9'h050,0, 32'hCAFE,0, 1,0,0,0, 9'h050,32'hCAFE, 1,0, 32'hA5A5A5A5};
      tv[8] = '{0,0,1,0, 0,9'h060, 0,32'hBEEF, 0,1,0,0, 9'h060,32'hBEEF, 0,1, 32'h5A5A5A5A};
      // reset with both requesters asking
      idle();
      bus.core_req = 1; bus.loader_req = 1;
      repeat (2) @(negedge clk);
      chk("rst_ctl", {bus.core_gnt, bus.core_stall, bus.core_rvalid, bus.loader_gnt,
                      bus.loader_rvalid, bus.ram_en, bus.ram_we}, 0);
      chk("rst_rdata", {bus.core_rdata, bus.loader_rdata}, 0);
      chk("rst_ram", {bus.ram_addr, bus.ram_wdata}, 0);
      nxt();
      rst_n = 1; bus.loader_req = 0; bus.core_addr = 9'h010;
      @(negedge clk);
      chk("first_gnt", {bus.core_gnt, bus.ram_en, bus.ram_we, bus.ram_addr}, {3'b110, 9'h010});
      nxt();
      idle();
      @(negedge clk);
      chk("first_rv", {bus.core_rvalid, bus.loader_rvalid}, 2'b10);
      chk("first_rd", bus.core_rdata, 32'hDEADBEEF);
      nxt();
      // single-cycle vector table, each followed by an idle cycle for the read return
      for (int i = 0; i < 9; i++) begin
         bus.core_req = tv[i].cr; bus.core_we = tv[i].cw;
         bus.core_addr = tv[i].ca; bus.core_wdata = tv[i].cd;
         bus.loader_req = tv[i].lr; bus.loader_we = tv[i].lw;
         bus.loader_addr = tv[i].la; bus.loader_wdata = tv[i].ld;
         @(negedge clk);
         chk($sformatf("tv%0d_ctl", i), {bus.core_gnt, bus.loader_gnt, bus.core_stall, bus.ram_en, bus.ram_we},
             {tv[i].cg, tv[i].lg, tv[i].st, tv[i].cg | tv[i].lg, tv[i].we});
         chk($sformatf("tv%0d_ram", i), {bus.ram_addr, bus.ram_wdata}, {tv[i].ea, tv[i].ed});
         nxt();
         idle();
         @(negedge clk);
         chk($sformatf("tv%0d_rv", i), {bus.core_rvalid, bus.loader_rvalid}, {tv[i].crv, tv[i].lrv});
         chk($sformatf("tv%0d_rd", i), {bus.core_rdata, bus.loader_rdata},
             {tv[i].crv ? tv[i].erd : 32'h0, tv[i].lrv ? tv[i].erd : 32'h0});
         nxt();
      end
      // aging with both requesters held
      bus.core_req = 1; bus.core_we = 1; bus.core_addr = 9'h020;
      bus.loader_req = 1; bus.loader_we = 1; bus.loader_addr = 9'h021;
      age_run("age", 18);
      // loader write then core read of the same word
      idle();
      nxt();
      we_cnt = 0;
      bus.loader_req = 1; bus.loader_we = 1; bus.loader_addr = 9'h1FF; bus.loader_wdata = 32'h12345678;
      @(negedge clk);
      we_cnt += int'(bus.ram_we);
      chk("wr_lgnt", bus.loader_gnt, 1);
      nxt();
      idle();
      bus.core_req = 1; bus.core_addr = 9'h1FF;
      @(negedge clk);
      we_cnt += int'(bus.ram_we);
      chk("wr_lrv", bus.loader_rvalid, 0);
      nxt();
      idle();
      @(negedge clk);
      we_cnt += int'(bus.ram_we);
      chk("wr_we_cnt", we_cnt, 1);
      chk("wr_rv", {bus.core_rvalid, bus.loader_rvalid}, 2'b10);
      chk("wr_rd", bus.core_rdata, 32'h12345678);
      nxt();
      // loader burst lock against a requesting core
      bus.loader_req = 1; bus.loader_we = 1; bus.loader_lock = 1; bus.loader_addr = 9'h030;
      @(negedge clk);
      chk("lk0_lgnt", bus.loader_gnt, 1);
      nxt();
      bus.core_req = 1; bus.core_addr = 9'h040;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("lk%0d", i), {bus.loader_gnt, bus.core_stall, bus.core_gnt}, {LOCK_EN, LOCK_EN, !LOCK_EN});
         nxt();
      end
      bus.loader_req = 0; bus.loader_lock = 0;
      @(negedge clk);
      chk("lk_drop_cgnt", bus.core_gnt, 1);
      nxt();
      // reset in the cycle after a granted locked loader read
      idle();
      bus.loader_req = 1; bus.loader_lock = 1; bus.loader_addr = 9'h010;
      @(negedge clk);
      chk("rr_lgnt", bus.loader_gnt, 1);
      nxt();
      rst_n = 0;
      idle();
      @(negedge clk);
      chk("rr_rv", {bus.loader_rvalid, bus.loader_rdata}, 0);
      nxt();
      rst_n = 1;
      @(negedge clk);
      chk("rr_rv_after", {bus.loader_rvalid, bus.core_rvalid}, 0);
      nxt();
      bus.core_req = 1; bus.core_we = 1; bus.loader_req = 1; bus.loader_lock = 1; bus.loader_we = 1;
      age_run("rr_age", 9);
      // reset while wait_cnt is partially counted
      bus.loader_lock = 0;
      age_run("rw_pre", 5);
      rst_n = 0;
      nxt();
      rst_n = 1;
      age_run("rw_age", 9);
      // randomized run against the rule model
      idle();
      rst_n = 0;
      nxt();
      rst_n = 1;
      for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
      m_wait = 0; m_locked = 0; p_v = 0; p_ld = 0; p_d = '0; c_pend = 0; l_pend = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         lock_act = LOCK_EN && m_locked && bus.loader_lock;
         force_l = bus.loader_req && m_wait == MW;
         elg = bus.loader_req && (lock_act || force_l || !bus.core_req);
         ecg = bus.core_req && !lock_act && !force_l;
         ga = ecg ? bus.core_addr : elg ? bus.loader_addr : '0;
         chk("rnd_ctl", {bus.core_gnt, bus.loader_gnt, bus.core_stall, bus.ram_en, bus.ram_we,
                         bus.core_rvalid, bus.loader_rvalid},
             {ecg, elg, bus.core_req && !ecg, ecg || elg,
              ecg ? bus.core_we : (elg && bus.loader_we), p_v && !p_ld, p_v && p_ld});
         chk("rnd_ram", {bus.ram_addr, bus.ram_wdata},
             {ga, ecg ? bus.core_wdata : elg ? bus.loader_wdata : 32'h0});
         chk("rnd_rdata", {bus.core_rdata, bus.loader_rdata},
             {(p_v && !p_ld) ? p_d : 32'h0, (p_v && p_ld) ? p_d : 32'h0});
         @(posedge clk);
         p_v = (ecg && !bus.core_we) || (elg && !bus.loader_we);
         p_ld = elg;
         p_d = ref_mem[ga];
         if (ecg && bus.core_we) ref_mem[ga] = bus.core_wdata;
         if (elg && bus.loader_we) ref_mem[ga] = bus.loader_wdata;
         m_wait = (!bus.loader_req || elg) ? 0 : (m_wait < MW ? m_wait + 1 : MW);
         m_locked = LOCK_EN && bus.loader_lock && (m_locked || elg);
         #1;
         if (ecg) c_pend = 0;
         if (elg) l_pend = 0;
         if (!c_pend) begin
            c_pend = $urandom_range(0, 9) < 7;
            bus.core_req = c_pend; bus.core_we = $urandom_range(0, 1);
            bus.core_addr = AW'($urandom_range(0, 31)); bus.core_wdata = $urandom;
         end
         if (!l_pend) begin
            l_pend = $urandom_range(0, 9) < 5;
            bus.loader_req = l_pend; bus.loader_we = $urandom_range(0, 1);
            bus.loader_addr = AW'($urandom_range(0, 31)); bus.loader_wdata = $urandom;
         end
         bus.loader_lock = $urandom_range(0, 3) != 0;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mips_datapath_memory_arbiter.md
# mips_datapath_memory_arbiter

Two-requester arbiter that shares the single-port data RAM of the MIPS datapath between the core's load/store path and a loader/debug port. Core has fixed priority; the loader is protected from starvation by an aging counter and can optionally lock the RAM for bursts. One access is granted per cycle, and read data returns one cycle after the grant, tagged to its owner. The arbiter sits between the memory datapath and the RAM and drives the core's stall.

## Interface
- ADDR_W, 9, RAM word address width
- DATA_W, 32, data word width
- MAX_WAIT, 8, consecutive denied loader cycles before the loader is forced through (1..255)

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- core_req / core_we  in  1 / 1  core access request, write strobe
- core_addr / core_wdata  in  ADDR_W / DATA_W  core address and write data
- core_gnt / core_stall  out  1 / 1  core granted this cycle; `core_req & ~core_gnt`
- core_rvalid / core_rdata  out  1 / DATA_W  core read data valid and data
- loader_req / loader_we / loader_lock  in  1 / 1 / 1  loader request, write strobe, burst lock
- loader_addr / loader_wdata  in  ADDR_W / DATA_W  loader address and write data
- loader_gnt  out  1  loader granted this cycle
- loader_rvalid / loader_rdata  out  1 / DATA_W  loader read data valid and data
- ram_en / ram_we  out  1 / 1  RAM access enable, write enable
- ram_addr / ram_wdata  out  ADDR_W / DATA_W  RAM address and write data
- ram_rdata  in  DATA_W  synchronous RAM read data, valid one cycle after `ram_en & ~ram_we`

## Operation
- State machine: IDLE, LOCKED. Reset enters IDLE.
- Grant rules in IDLE, evaluated combinationally each cycle:
  - loader wins if `wait_cnt == MAX_WAIT`;
  - otherwise core wins if `core_req`;
  - otherwise loader wins if `loader_req`.
- Grant rule in LOCKED: only the loader is granted; the core stalls.
- At most one grant per cycle.
- `ram_*` are muxed from the granted requester. `ram_en = core_gnt | loader_gnt`. Addresses and data are zero when there is no grant.
- Requesters hold req, we, addr and wdata stable until granted. A grant completes the access; there is no retry.
- wait_cnt:
  - +1 each cycle `loader_req & ~loader_gnt`, saturating at MAX_WAIT;
  - cleared on loader grant or on `~loader_req`.
- Read return: a registered owner tag plus valid bit. `<x>_rvalid` is 1 in the cycle after a granted read by `<x>`. `<x>_rdata = ram_rdata` when `<x>_rvalid`, else 0.
- Writes never produce an rvalid.
- Transitions:
  - IDLE→LOCKED when `loader_gnt & loader_lock`.
  - LOCKED→IDLE at the clock edge where `loader_lock == 0`. In that same cycle, arbitration already uses the IDLE rules.
- Reset mid-operation: a pending rvalid is dropped and is not reissued after reset; state returns to IDLE; wait_cnt clears.

## Timing
- Reset values: all outputs 0. Grants are forced to 0 while rst_n is low.
- Grant and RAM control are combinational from requests and state, with zero-cycle grant latency.
- Read latency: grant in cycle t, rvalid and rdata in cycle t+1. Back-to-back reads give one rvalid per cycle.
- Worst-case loader latency in IDLE: MAX_WAIT+1 cycles from its first request.
- Simultaneous requests: core wins, unless wait_cnt is saturated or the state is LOCKED.

## Configuration
- `MIPS_DATAPATH_MEMORY_ARBITER_LOCK_EN`
  - Defined: LOCKED state and the `loader_lock` behaviour exist as described.
  - Undefined: `loader_lock` is ignored, the FSM stays in IDLE, and only core priority plus aging apply. The port remains present for a stable interface.

## Structure
- Shared package holds:
  - state encodings IDLE and LOCKED;
  - owner tag encodings CORE and LOADER;
  - the default MAX_WAIT;
  - the wait_cnt width function, `clog2(MAX_WAIT+1)`.
- One sub-module, `mips_datapath_memory_arbiter_age`, holds the saturating wait counter with inc, clr and sat outputs.
- Grant mux, FSM and read-return register live in the top.

## Test plan
- Reset with both requests high → all outputs 0. After release, core read at addr 0x010 is granted in the first cycle; core_rvalid is 1 in the next cycle with ram_rdata 0xDEADBEEF.
- core_req and loader_req held high, MAX_WAIT=8 → core is granted 8 cycles, the loader is granted in cycle 9 (core_stall=1 there), wait_cnt then clears and the pattern repeats.
- Loader write of 0x12345678 to 0x1FF, then a core read of 0x1FF → ram_we=1 for exactly one cycle. The core read returns 0x12345678, and loader_rvalid stays 0.
- LOCK_EN defined, loader holds lock for 4 granted accesses with core_req high → core_stall=1 for all 4 cycles. After lock drops, the core is granted on the next cycle.
- LOCK_EN undefined, same stimulus → the core wins every cycle until the aging threshold.
- Assert rst_n low in the cycle after a granted loader read → loader_rvalid stays 0 and the FSM and wait_cnt return to reset values.
